seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Display controller that owns the board's multi-digit seven-segment display.
- Time-multiplexes NUM_DIG digit positions from a packed glyph-code bus, with a one-cycle anti-ghost blank between digits.
- Contains the seconds countdown engine used by the FSM wait state. While the countdown runs, its value overrides digit 0.
- Sits between the main FSM/result formatter and the board pins. It replaces per-state segment decoding with a single scheduler.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- FRAME_HZ, 1000, full-display refresh rate; SCAN_DIV = CLK_HZ/(FRAME_HZ*NUM_DIG) clocks per digit slot, must be >= 2.
- NUM_DIG, 8, number of digit positions (2..8).
- SEC_DIV, CLK_HZ, clocks per countdown second.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset: synchronous, active-high.
- digit_code, input, NUM_DIG*5, glyph code per digit; digit i occupies bits [5i+4:5i].
- digit_en, input, NUM_DIG, per-digit enable; 0 blanks that slot.
- cnt_start, input, 1, single-cycle pulse: load and start countdown.
- cnt_load, input, 4, countdown start value, 0..9; values above 9 are saturated to 9.
- cnt_abort, input, 1, single-cycle pulse: stop countdown.
- an, output, NUM_DIG, digit anodes, active-low.
- seg, output, 7, segments {a,b,c,d,e,f,g}, active-low.
- cnt_val, output, 4, current countdown value.
- cnt_busy, output, 1, countdown running.
- cnt_done, output, 1, one-cycle pulse when countdown reaches 0.

Behaviour:
- Reset: an=all 1s, seg=7'h7F, cnt_val=0, cnt_busy=0, cnt_done=0, scan index=0, both dividers=0.
- Reset asserted mid-countdown: the countdown is lost and no cnt_done is issued.
- Scan divider counts 0..SCAN_DIV-1. At terminal it wraps to 0 and the index advances; index NUM_DIG-1 wraps to 0.
- Slot timing, relative to the divider: count 0 is the blank cycle (an=all 1s, seg=7'h7F). Counts 1..SCAN_DIV-1 drive the digit.
- Driving a digit: an has only bit[idx] low, and seg = glyph(code). If digit_en[idx]=0, an stays all 1s for the whole slot.
- an and seg are registered and reflect digit_code sampled one cycle earlier. digit_code may change at any time, with no handshake.
- Glyph codes: 0-9 are digits, 10=A, 11=b, 12=C, 13=d, 14=E, 15=F, 16=t, 17=n, 18=I, 19=G, 20=S, 21=dash (g only). All other codes (22-31) are blank.
- Countdown states: IDLE and RUN.
  - IDLE + cnt_start, cnt_load>0: next cycle cnt_val=load, cnt_busy=1, sec divider cleared, state RUN.
  - IDLE + cnt_start, cnt_load=0: next cycle cnt_done=1 for one cycle, cnt_val=0, state stays IDLE, busy never asserts.
  - RUN, each SEC_DIV-th clock: cnt_val decrements. On 1->0, in the same update, cnt_busy=0, cnt_done=1 for one cycle, state IDLE.
  - cnt_start while RUN: ignored.
  - cnt_abort while RUN: next cycle cnt_busy=0, cnt_val=0, state IDLE, no cnt_done.
  - cnt_abort and cnt_start in the same cycle: abort wins, so the countdown is not started.
  - cnt_abort in IDLE: no effect.
- While cnt_busy=1, digit 0 shows glyph(cnt_val), forced enabled, regardless of digit_code/digit_en.
- The sec divider runs only in RUN. The scan divider runs continuously after reset.

Decomposition:
- Package seg_pkg holds:
  - Glyph code localparams: GL_0..GL_9, GL_A, GL_B, GL_C, GL_D, GL_E, GL_F, GL_T, GL_N, GL_I, GL_G, GL_S, GL_DASH, GL_BLANK.
  - The 7-bit active-low segment constants.
  - The SEG_OFF = 7'h7F constant.
- Sub-module seg_glyph_rom: combinational 5-bit code -> 7-bit active-low segments. It is reused by any other display driver.
- Countdown engine and scanner stay in the top module.

Test Plan:
Bench parameters are CLK_HZ=80, FRAME_HZ=5, NUM_DIG=4 (SCAN_DIV=4), SEC_DIV=8.
1. Reset release, digit_en=4'hF, codes {3,2,1,0} (digit3..0):
   - Digits cycle 0,1,2,3,0.
   - Each slot is 1 blank cycle then 3 cycles, e.g. an=4'b1110 with seg=7'b0000001, then 4'b1101 with seg=7'b1001111.
2. digit_en=4'b1011:
   - Slot 2 keeps an=4'hF for all 4 cycles.
   - Code 25 on digit 3 gives seg=7'h7F with an=4'b0111.
3. cnt_start with cnt_load=3:
   - cnt_busy=1 next cycle, and digit 0 shows 7'b0000110.
   - cnt_val goes 3,2,1,0, each step 8 clocks apart.
   - cnt_done is high exactly one cycle, coincident with busy falling.
4. cnt_load=0 start:
   - cnt_done pulses next cycle, and cnt_busy stays 0 throughout.
   - cnt_load=12 start: cnt_val=9.
5. Abort:
   - Abort at cnt_val=2 gives busy=0 and val=0, with no done pulse.
   - Abort and start in the same cycle from IDLE: busy stays 0.
   - Start while RUN at val=2: val is unaffected.
6. Assert rst mid-countdown and mid-slot:
   - Next cycle all outputs are at their reset values, with no cnt_done.
   - Scanning restarts at digit 0 with a blank cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for seven-segment display drivers: glyph codes,
// active-low segment patterns ({a,b,c,d,e,f,g}) and the countdown state type.
package seg_pkg;

  localparam logic [4:0] GL_0     = 5'd0;
  localparam logic [4:0] GL_1     = 5'd1;
  localparam logic [4:0] GL_2     = 5'd2;
  localparam logic [4:0] GL_3     = 5'd3;
  localparam logic [4:0] GL_4     = 5'd4;
  localparam logic [4:0] GL_5     = 5'd5;
  localparam logic [4:0] GL_6     = 5'd6;
  localparam logic [4:0] GL_7     = 5'd7;
  localparam logic [4:0] GL_8     = 5'd8;
  localparam logic [4:0] GL_9     = 5'd9;
  localparam logic [4:0] GL_A     = 5'd10;
  localparam logic [4:0] GL_B     = 5'd11;
  localparam logic [4:0] GL_C     = 5'd12;
  localparam logic [4:0] GL_D     = 5'd13;
  localparam logic [4:0] GL_E     = 5'd14;
  localparam logic [4:0] GL_F     = 5'd15;
  localparam logic [4:0] GL_T     = 5'd16;
  localparam logic [4:0] GL_N     = 5'd17;
  localparam logic [4:0] GL_I     = 5'd18;
  localparam logic [4:0] GL_G     = 5'd19;
  localparam logic [4:0] GL_S     = 5'd20;
  localparam logic [4:0] GL_DASH  = 5'd21;
  localparam logic [4:0] GL_BLANK = 5'd31;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b1100000;
  localparam logic [6:0] SEG_C    = 7'b0110001;
  localparam logic [6:0] SEG_D    = 7'b1000010;
  localparam logic [6:0] SEG_E    = 7'b0110000;
  localparam logic [6:0] SEG_F    = 7'b0111000;
  localparam logic [6:0] SEG_T    = 7'b1110000;
  localparam logic [6:0] SEG_N    = 7'b1101010;
  localparam logic [6:0] SEG_I    = 7'b1111001;
  localparam logic [6:0] SEG_G    = 7'b0100001;
  localparam logic [6:0] SEG_S    = 7'b0100100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    CNT_IDLE = 1'b0,
    CNT_RUN  = 1'b1
  } cnt_state_e;

  function automatic logic [3:0] sat_load(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph decoder: 5-bit glyph code to active-low segments.
import seg_pkg::*;

module seg_glyph_rom (
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      GL_0:    seg_o = SEG_0;
      GL_1:    seg_o = SEG_1;
      GL_2:    seg_o = SEG_2;
      GL_3:    seg_o = SEG_3;
      GL_4:    seg_o = SEG_4;
      GL_5:    seg_o = SEG_5;
      GL_6:    seg_o = SEG_6;
      GL_7:    seg_o = SEG_7;
      GL_8:    seg_o = SEG_8;
      GL_9:    seg_o = SEG_9;
      GL_A:    seg_o = SEG_A;
      GL_B:    seg_o = SEG_B;
      GL_C:    seg_o = SEG_C;
      GL_D:    seg_o = SEG_D;
      GL_E:    seg_o = SEG_E;
      GL_F:    seg_o = SEG_F;
      GL_T:    seg_o = SEG_T;
      GL_N:    seg_o = SEG_N;
      GL_I:    seg_o = SEG_I;
      GL_G:    seg_o = SEG_G;
      GL_S:    seg_o = SEG_S;
      GL_DASH: seg_o = SEG_DASH;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with a one-cycle anti-ghost blank per slot,
// plus the seconds countdown engine whose value overrides digit 0 while running.
//
// state    | meaning
// CNT_IDLE | countdown stopped, waiting for cnt_start
// CNT_RUN  | counting down one step every SEC_DIV clocks
import seg_pkg::*;

module seg_scan_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int FRAME_HZ = 1000,
  parameter int NUM_DIG  = 8,
  parameter int SEC_DIV  = CLK_HZ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_DIG*5-1:0] digit_code,
  input  logic [NUM_DIG-1:0]   digit_en,
  input  logic                 cnt_start,
  input  logic [3:0]           cnt_load,
  input  logic                 cnt_abort,
  output logic [NUM_DIG-1:0]   an,
  output logic [6:0]           seg,
  output logic [3:0]           cnt_val,
  output logic                 cnt_busy,
  output logic                 cnt_done
);

  localparam int SCAN_DIV = CLK_HZ / (FRAME_HZ * NUM_DIG);
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SEC_W    = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int IDX_W    = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  cnt_state_e          state_q, state_d;
  logic [3:0]          val_q, val_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic                done_q, done_d;
  logic [SCAN_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_DIG-1:0]  an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          load_sat;
  logic                busy_d;
  logic [4:0]          code_sel;
  logic                show;
  logic [6:0]          rom_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CNT_IDLE;
      val_q   <= '0;
      sec_q   <= '0;
      done_q  <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign load_sat = sat_load(cnt_load);

  // Abort has priority over start in every state.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    case (state_q)
      CNT_IDLE: begin
        if (cnt_start && !cnt_abort) begin
          if (load_sat != 4'd0) begin
            state_d = CNT_RUN;
            val_d   = load_sat;
            sec_d   = '0;
          end else begin
            val_d  = 4'd0;
            done_d = 1'b1;
          end
        end
      end
      CNT_RUN: begin
        if (cnt_abort) begin
          state_d = CNT_IDLE;
          val_d   = 4'd0;
          sec_d   = '0;
        end else if (sec_q == SEC_W'(SEC_DIV - 1)) begin
          sec_d = '0;
          val_d = val_q - 4'd1;
          if (val_q == 4'd1) begin
            state_d = CNT_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end
      default: state_d = CNT_IDLE;
    endcase
  end

  assign busy_d = (state_d == CNT_RUN);

  always_comb begin
    div_d = div_q + SCAN_W'(1);
    idx_d = idx_q;
    if (div_q == SCAN_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Output registers are fed from next-state values so an/seg line up with
  // the divider and countdown registers on the same cycle.
  always_comb begin
    code_sel = GL_BLANK;
    show     = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_d == IDX_W'(i)) begin
        code_sel = digit_code[5*i +: 5];
        show     = digit_en[i];
      end
    end
    if (busy_d && idx_d == '0) begin
      code_sel = {1'b0, val_d};
      show     = 1'b1;
    end
  end

  seg_glyph_rom u_glyph (
    .code_i (code_sel),
    .seg_o  (rom_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (div_d != '0 && show) begin
      an_d  = ~(NUM_DIG'(1) << idx_d);
      seg_d = rom_seg;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign cnt_val  = val_q;
  assign cnt_busy = (state_q == CNT_RUN);
  assign cnt_done = done_q;

endmodule
